t03_sprite_loader: RTL and testbench
====================================

T03_SPRITE_LOADER -- requirements
Module: t03_sprite_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 300: sprite size in pixels, 15 wide by 20 tall, row-major.
REQ-002 Parameter PIX_W, default 8: bits per pixel (color byte).
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse that begins loading a new sprite.
REQ-006 in_data  input  8  pixel color byte.
REQ-007 in_valid  input  1  in_data holds a valid byte.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 frame_end  input  1  one-cycle pulse marking the end of the visible frame; this is the only legal commit point.
REQ-010 player  output  NUM_PIXELS*PIX_W (2400)  active sprite bitmap feeding the display block.
REQ-011 busy  output  1  high in LOAD or PENDING.
REQ-012 load_done  output  1  one-cycle pulse when a new sprite has been committed to player.
REQ-013 abort  output  1  one-cycle pulse when a load in progress or pending is discarded by start.

Function
REQ-014 The block shall hold two 2400-bit buffers: a back buffer (written by the stream) and the active buffer driven on player.
REQ-015 States: IDLE, LOAD, PENDING, COMMIT.
REQ-016 IDLE: start moves to LOAD with pixel counter = 0; all other inputs are ignored.
REQ-017 LOAD: in_ready = 1 combinationally from state; in_ready = 0 in every other state.
REQ-018 Transfer occurs when in_valid && in_ready; the byte is written to back[(NUM_PIXELS-1-k)*8 +: 8], where k is the current counter value, so the first byte occupies bits 2399:2392.
REQ-019 Counter: 9 bits, increments by 1 per transfer, never exceeds NUM_PIXELS-1, no wrap.
REQ-020 A transfer at k = NUM_PIXELS-1 moves to PENDING on the next edge.
REQ-021 in_valid low in LOAD stalls the load indefinitely with no timeout; the counter holds.
REQ-022 PENDING: frame_end moves to COMMIT.
REQ-023 COMMIT lasts one cycle: the active buffer is loaded from the back buffer, load_done = 1, and the next state is IDLE.
REQ-024 player changes only at COMMIT exit, i.e. on the edge following the frame_end cycle; latency from frame_end to the new player value is 2 edges.
REQ-025 Registers are therefore never torn mid-frame.
REQ-026 Bytes equal to 0x00 are stored unmodified; transparency handling belongs to the display block.
REQ-027 frame_end in IDLE, LOAD or COMMIT shall have no effect.
REQ-028 A frame_end in the same cycle as the final transfer is not honored; commit waits for the next frame_end.
REQ-029 start in LOAD or PENDING shall:
- pulse abort for one cycle;
- reset the counter to 0;
- remain in (or return to) LOAD;
- leave the active buffer unchanged.
REQ-030 start and frame_end together in PENDING: start wins, no commit, abort = 1.
REQ-031 start in COMMIT is ignored: the commit completes and the block goes to IDLE.
REQ-032 A transfer and start in the same LOAD cycle: the byte is discarded and the counter becomes 0.
REQ-033 busy = (state == LOAD || state == PENDING), registered from state only.

Reset
REQ-034 While rst = 0 at a clock edge, the block shall enter IDLE with:
- counter = 0;
- back and active buffers all zero, so player = 0;
- in_ready = 0, busy = 0, load_done = 0, abort = 0.
REQ-035 Reset asserted mid-LOAD or mid-PENDING discards all partial data; after release no commit occurs until a new start and a full load.

Verification
REQ-036 Basic load: start, then 300 bytes 0x01..0x2C (wrapping mod 256) with in_valid held high, then frame_end -> in_ready high for exactly 300 cycles, player[2399:2392] = 0x01, player[7:0] = 0x2C, one load_done pulse 2 edges after frame_end.
REQ-037 Back-pressure: toggle in_valid every cycle during the load -> identical player contents; busy stays high throughout.
REQ-038 Commit gating: complete a load without frame_end for 1000 cycles -> player unchanged (all zero), state PENDING, in_ready = 0; then frame_end -> commit.
REQ-039 Abort: start after 150 bytes -> abort pulse, counter = 0; then 300 bytes of 0xAA and frame_end -> player is all 0xAA and the previous active image is untouched until the commit.
REQ-040 Collisions:
- frame_end on the final-transfer cycle -> no commit;
- start together with frame_end in PENDING -> abort pulse, no load_done.
REQ-041 Reset mid-operation: rst = 0 for 1 cycle at byte 200 -> all outputs return to their reset values; a later frame_end produces no load_done.

Source files
------------

// File: rtl/t03_sprite_loader.sv
// rtl/t03_sprite_loader.sv - double-buffered sprite loader; streams pixels into a back buffer, commits at frame end
module t03_sprite_loader #(
   parameter int NUM_PIXELS = 300,
   parameter int PIX_W      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [PIX_W-1:0]            in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        frame_end,
   output logic [NUM_PIXELS*PIX_W-1:0] player,
   output logic                        busy,
   output logic                        load_done,
   output logic                        abort
);

   localparam int W  = NUM_PIXELS * PIX_W;
   localparam int CW = $clog2(NUM_PIXELS);
   localparam int IW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, PENDING, COMMIT} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  back;
   logic [IW-1:0] wr_base;

   // First byte of the stream lands in the most significant pixel slot.
   assign wr_base  = IW'((NUM_PIXELS - 1 - int'(cnt)) * PIX_W);
   assign in_ready = (state == LOAD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         back      <= '0;
         player    <= '0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         abort     <= 1'b0;
      end else begin
         load_done <= 1'b0;
         abort     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (start) begin
                  cnt   <= '0;
                  abort <= 1'b1;
               end else if (in_valid) begin
                  back[wr_base +: PIX_W] <= in_data;
                  if (cnt == LAST) begin
                     state <= PENDING;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            PENDING: begin
               // A restart outranks a simultaneous frame end.
               if (start) begin
                  state <= LOAD;
                  cnt   <= '0;
                  abort <= 1'b1;
               end else if (frame_end) begin
                  state <= COMMIT;
                  busy  <= 1'b0;
               end
            end
            COMMIT: begin
               player    <= back;
               load_done <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t03_sprite_loader.sv
// tb/tb_t03_sprite_loader.sv - table, directed and randomized checks of t03_sprite_loader
module tb_t03_sprite_loader;

   localparam int NP = 300;
   localparam int W  = NP * 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         frame_end = 1'b0;
   logic [W-1:0] player;
   logic         busy;
   logic         load_done;
   logic         abort;

   t03_sprite_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .frame_end(frame_end), .player(player), .busy(busy),
      .load_done(load_done), .abort(abort)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference: bytes collected so far, plus what the display should currently show.
   bit           m_loading = 0, m_waiting = 0, m_committing = 0;
   byte unsigned m_q[$];
   logic [W-1:0] m_player = '0;
   bit           e_ld = 0, e_ab = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else begin
         int first;
         first = -1;
         for (int i = NP - 1; i >= 0; i--)
            if (act[(NP-1-i)*8 +: 8] !== exp[(NP-1-i)*8 +: 8]) first = i;
         $display("FAIL %s: pixel %0d got %0h expected %0h", name, first,
                  act[(NP-1-first)*8 +: 8], exp[(NP-1-first)*8 +: 8]);
      end
   endtask

   function automatic logic [W-1:0] ramp_vec();
      logic [W-1:0] v;
      for (int i = 0; i < NP; i++) v[(NP-1-i)*8 +: 8] = 8'(i + 1);
      return v;
   endfunction

   function automatic logic [W-1:0] fill_vec(input logic [7:0] b);
      logic [W-1:0] v;
      for (int i = 0; i < NP; i++) v[i*8 +: 8] = b;
      return v;
   endfunction

   task automatic model_step(input bit st, input bit v, input logic [7:0] d, input bit fe, input bit r);
      e_ld = 0;
      e_ab = 0;
      if (!r) begin
         m_loading = 0; m_waiting = 0; m_committing = 0;
         m_q.delete();
         m_player = '0;
      end else if (m_committing) begin
         for (int i = 0; i < NP; i++) m_player[(NP-1-i)*8 +: 8] = m_q[i];
         e_ld = 1;
         m_committing = 0;
      end else if (st) begin
         e_ab = m_loading || m_waiting;
         m_q.delete();
         m_loading = 1;
         m_waiting = 0;
      end else if (m_loading && v) begin
         m_q.push_back(d);
         if (m_q.size() == NP) begin
            m_loading = 0;
            m_waiting = 1;
         end
      end else if (m_waiting && fe) begin
         m_waiting = 0;
         m_committing = 1;
      end
   endtask

   task automatic cycle(input bit st, input bit v, input logic [7:0] d, input bit fe, input bit r);
      start = st; in_valid = v; in_data = d; frame_end = fe; rst = r;
      model_step(st, v, d, fe, r);
      @(posedge clk);
      #1;
      chk("in_ready", in_ready, m_loading);
      chk("busy", busy, m_loading || m_waiting);
      chk("load_done", load_done, e_ld);
      chk("abort", abort, e_ab);
      chk_vec("player", player, m_player);
      start = 0; in_valid = 0; frame_end = 0; rst = 1;
   endtask

   task automatic feed(input int n, input bit aa, input bit toggle, output int busy_low);
      int sent;
      sent = 0;
      busy_low = 0;
      for (int c = 0; c < 4*n + 8 && sent < n; c++) begin
         bit v, rdy;
         v = toggle ? (c[0] == 1'b0) : 1'b1;
         rdy = in_ready;
         cycle(0, v, aa ? 8'hAA : 8'(sent + 1), 0, 1);
         if (v && rdy) sent++;
         if (!busy) busy_low++;
      end
      chk("feed_count", sent, n);
   endtask

   typedef struct {
      bit r, st, v;
      logic [7:0] d;
      bit fe;
      bit e_ir, e_busy, e_ld, e_ab;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int bl, ir, cnt_ld;
      bit rdy;

      tbl[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 1, 0, 8'h00, 0, 1, 1, 0, 0};
      tbl[4]  = '{1, 0, 1, 8'h11, 0, 1, 1, 0, 0};
      tbl[5]  = '{1, 0, 0, 8'h22, 0, 1, 1, 0, 0};
      tbl[6]  = '{1, 1, 1, 8'h33, 0, 1, 1, 0, 1};
      tbl[7]  = '{1, 0, 1, 8'h44, 1, 1, 1, 0, 0};
      tbl[8]  = '{1, 1, 0, 8'h00, 0, 1, 1, 0, 1};
      tbl[9]  = '{0, 0, 1, 8'h55, 0, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0};

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].r);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d_load_done", i), load_done, tbl[i].e_ld);
         chk($sformatf("tbl%0d_abort", i), abort, tbl[i].e_ab);
      end
      chk_vec("reset_player_zero", player, '0);

      // Basic load with in_valid held high.
      cycle(1, 0, 0, 0, 1);
      ir = 0;
      bl = 0;
      for (int c = 0; c < 310; c++) begin
         rdy = in_ready;
         if (rdy) ir++;
         cycle(0, 1, 8'(bl + 1), 0, 1);
         if (rdy) bl++;
      end
      chk("basic_ready_cycles", ir, 300);
      chk("basic_pending_busy", busy, 1);
      chk("basic_pending_ready", in_ready, 0);
      cycle(0, 0, 0, 1, 1);
      chk("basic_ld_early", load_done, 0);
      chk_vec("basic_player_held", player, '0);
      cycle(0, 0, 0, 0, 1);
      chk("basic_ld", load_done, 1);
      chk("basic_first_byte", player[W-1 -: 8], 8'h01);
      chk("basic_last_byte", player[7:0], 8'h2C);
      cycle(0, 0, 0, 0, 1);
      chk("basic_ld_single", load_done, 0);

      // Back-pressure gives the same image; busy never drops.
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 1);
      feed(300, 0, 1, bl);
      chk("bp_busy_low", bl, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      chk("bp_ld", load_done, 1);
      chk_vec("bp_player", player, ramp_vec());

      // Commit gating from a cleared display.
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 1);
      feed(300, 0, 0, bl);
      for (int c = 0; c < 1000; c++) cycle(0, 0, 0, 0, 1);
      chk_vec("gate_player_zero", player, '0);
      chk("gate_busy", busy, 1);
      chk("gate_ready", in_ready, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      chk("gate_ld", load_done, 1);
      chk_vec("gate_player", player, ramp_vec());

      // Abort halfway, then a full 0xAA image.
      cycle(1, 0, 0, 0, 1);
      feed(150, 0, 0, bl);
      cycle(1, 0, 0, 0, 1);
      chk("abort_pulse", abort, 1);
      cycle(0, 0, 0, 0, 1);
      chk("abort_single", abort, 0);
      feed(300, 1, 0, bl);
      chk_vec("abort_old_image", player, ramp_vec());
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      chk("abort_ld", load_done, 1);
      chk_vec("abort_player_aa", player, fill_vec(8'hAA));

      // frame_end on the final transfer is not a commit.
      cycle(1, 0, 0, 0, 1);
      feed(299, 0, 0, bl);
      cycle(0, 1, 8'h2C, 1, 1);
      chk("coll_pending", busy, 1);
      chk("coll_ready", in_ready, 0);
      cnt_ld = 0;
      for (int c = 0; c < 6; c++) begin
         cycle(0, 0, 0, 0, 1);
         if (load_done) cnt_ld++;
      end
      chk("coll_no_commit", cnt_ld, 0);
      chk_vec("coll_player", player, fill_vec(8'hAA));
      cycle(1, 0, 0, 1, 1);
      chk("coll_start_fe_abort", abort, 1);
      chk("coll_start_fe_ready", in_ready, 1);
      cnt_ld = 0;
      for (int c = 0; c < 4; c++) begin
         cycle(0, 0, 0, 0, 1);
         if (load_done) cnt_ld++;
      end
      chk("coll_start_fe_no_ld", cnt_ld, 0);

      // Reset at byte 200 discards everything.
      feed(200, 0, 0, bl);
      cycle(0, 0, 0, 0, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ld", load_done, 0);
      chk("rst_abort", abort, 0);
      chk_vec("rst_player", player, '0);
      cnt_ld = 0;
      cycle(0, 0, 0, 1, 1);
      for (int c = 0; c < 4; c++) begin
         cycle(0, 0, 0, c == 1, 1);
         if (load_done) cnt_ld++;
      end
      chk("rst_no_ld", cnt_ld, 0);

      // Randomized traffic against the reference.
      for (int c = 0; c < 6000; c++) begin
         bit st, v, fe, r;
         st = (m_loading || m_waiting) ? ($urandom % 400 == 0) : ($urandom % 20 == 0);
         v  = ($urandom % 4 != 0);
         fe = ($urandom % 8 == 0);
         r  = ($urandom % 3000 != 0);
         cycle(st, v, 8'($urandom), fe, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
